// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the bit-serial adder sequencer.
//   state_t   : FSM state encoding (2 bits, code 2'b11 unused)
//   DEFAULT_W : default operand/result width
// -----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle between an issuing master and the serial adder.
//   start      : request a new addition (master -> slave)
//   opA, opB   : W-bit operands          (master -> slave)
//   cin        : carry-in                (master -> slave)
//   busy       : bits being processed    (slave -> master)
//   done       : one-cycle result pulse  (slave -> master)
//   sum, cout  : registered result       (slave -> master)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int W = DEFAULT_W
) ();

   logic         start;
   logic [W-1:0] opA;
   logic [W-1:0] opB;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output start, opA, opB, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, opA, opB, cin,
      output busy, done, sum, cout
   );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_full_gate.sv
// -----------------------------------------------------------------------------
// full_gate
// Single 1-bit full-adder cell.
//   inA, inB : addend bits
//   Cin      : carry in
//   outS2    : sum bit
//   Cout0    : carry out
// -----------------------------------------------------------------------------
module full_gate (
   input  logic inA,
   input  logic inB,
   input  logic Cin,
   output logic outS2,
   output logic Cout0
);

   assign outS2 = inA ^ inB ^ Cin;
   assign Cout0 = (inA & inB) | (inA & Cin) | (inB & Cin);

endmodule : full_gate

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder sequencer: one full_gate cell is time-multiplexed over
// W-bit operands, LSB first, with the carry held in a flop between bits.
// {cout,sum} = opA + opB + cin after W RUN cycles, followed by a one-cycle
// DONE state. Back-to-back issue is accepted from DONE.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : serial_add_ctrl_if.slave (start/opA/opB/cin in, busy/done/sum/cout out)
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter  int W     = DEFAULT_W,
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic             clk,
   input  logic             rst,
   serial_add_ctrl_if.slave bus
);

   state_t             state_q, state_d;
   logic [W-1:0]       a_sh_q, b_sh_q, s_sh_q;
   logic [W-1:0]       sum_q;
   logic               carry_q, cout_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               fa_s, fa_c;
   logic               load;
   logic               last_bit;
   logic [W:0]         s_ext;

   full_gate full_gate_0 (
      .inA   (a_sh_q[0]),
      .inB   (b_sh_q[0]),
      .Cin   (carry_q),
      .outS2 (fa_s),
      .Cout0 (fa_c)
   );

   // A new request is only accepted when no addition is in flight.
   assign load     = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign last_bit = (cnt_q == CNT_W'(W - 1));
   // New sum bit enters at the MSB; slicing [W:1] keeps this legal for W=1.
   assign s_ext    = {fa_s, s_sh_q};

   // ---------------- state register ----------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   // NOTE: state_d is given a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (last_bit)  state_d = ST_DONE;
         ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- outputs (registered state decode only) ----------------
   always_comb begin
      bus.busy = (state_q == ST_RUN);
      bus.done = (state_q == ST_DONE);
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (load) begin
         a_sh_q  <= bus.opA;
         b_sh_q  <= bus.opB;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
         a_sh_q  <= a_sh_q >> 1;
         b_sh_q  <= b_sh_q >> 1;
         s_sh_q  <= s_ext[W:1];
         carry_q <= fa_c;
         // Counter parks at 0 on the final bit so W=1 never leaves 0.
         cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
         if (last_bit) begin
            sum_q  <= s_ext[W:1];
            cout_q <= fa_c;
         end
      end
   end

endmodule : serial_add_ctrl
